// File: rtl/mcu_shared_ram_arbiter.sv
// mcu_shared_ram_arbiter: shares a byte-wide RAM between the CPU and the 8051 using a request/ack handshake, an MCU stall and a mailbox irq; MCU_WRITE_POSTING_EN adds a 1-entry posted MCU write buffer.
module mcu_shared_ram_arbiter #(
  parameter int AW = 12,
  parameter int DW = 8,
  parameter int MCU_MAX_WAIT = 4,
  parameter logic [AW-1:0] INT_ADDR = AW'(12'hFFF)
) (
  input  logic          CLK_32M,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_ack,
  input  logic          mcu_req,
  input  logic          mcu_we,
  input  logic [AW-1:0] mcu_addr,
  input  logic [DW-1:0] mcu_din,
  output logic [DW-1:0] mcu_dout,
  output logic          mcu_ack,
  output logic          mcu_stall,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          ram_cs,
  output logic          ram_we,
  output logic          mcu_int
);
  localparam int CW = $clog2(MCU_MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, GRANT, DATA} state_t;
  state_t state;
  logic cpu_pend, cpu_we_q, mcu_pend, mcu_we_q;
  logic [AW-1:0] cpu_addr_q, mcu_addr_q;
  logic [DW-1:0] cpu_din_q, mcu_din_q, cpu_dout_q, mcu_dout_q;
  logic sel_mcu, sel_pb, cpu_rd, mcu_rd;
  logic [CW-1:0] starve;
  logic cpu_done, mcu_done, cpu_take, mcu_take, pb_v, pb_take, mcu_any, pick_mcu;
  logic g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_din;
  assign cpu_done = state == DATA && !sel_mcu;
  assign mcu_done = state == DATA && sel_mcu && !sel_pb;
  assign cpu_take = cpu_req && (!cpu_pend || cpu_done);
  assign mcu_any = mcu_pend || pb_v;
  assign pick_mcu = mcu_any && (!cpu_pend || starve >= CW'(MCU_MAX_WAIT));
  assign mcu_stall = mcu_pend;
  assign cpu_dout = cpu_rd ? ram_rdata : cpu_dout_q;
  assign mcu_dout = mcu_rd ? ram_rdata : mcu_dout_q;
`ifdef MCU_WRITE_POSTING_EN
  logic [AW-1:0] pb_addr;
  logic [DW-1:0] pb_din;
  assign pb_take = mcu_req && mcu_we && !pb_v && (!mcu_pend || mcu_done);
  assign mcu_take = mcu_req && !pb_take && (!mcu_pend || mcu_done);
  assign {g_we, g_addr, g_din} = pb_v ? {1'b1, pb_addr, pb_din} : {mcu_we_q, mcu_addr_q, mcu_din_q};
  // posted MCU write buffer: filled by a write strobe, drained by an MCU grant without ack
  always_ff @(posedge CLK_32M or negedge reset_n)
    if (!reset_n) begin
      pb_v <= 1'b0;
      pb_addr <= '0;
      pb_din <= '0;
    end else if (pb_take) begin
      pb_v <= 1'b1;
      pb_addr <= mcu_addr;
      pb_din <= mcu_din;
    end else if (state == DATA && sel_pb) pb_v <= 1'b0;
`else
  assign pb_v = 1'b0;
  assign pb_take = 1'b0;
  assign mcu_take = mcu_req && (!mcu_pend || mcu_done);
  assign {g_we, g_addr, g_din} = {mcu_we_q, mcu_addr_q, mcu_din_q};
`endif
  // pending slots: a strobe is taken when the slot is empty or retiring in its ack cycle
  always_ff @(posedge CLK_32M or negedge reset_n)
    if (!reset_n) begin
      {cpu_pend, cpu_we_q, cpu_addr_q, cpu_din_q} <= '0;
      {mcu_pend, mcu_we_q, mcu_addr_q, mcu_din_q} <= '0;
    end else begin
      if (cpu_take) {cpu_pend, cpu_we_q, cpu_addr_q, cpu_din_q} <= {1'b1, cpu_we, cpu_addr, cpu_din};
      else if (cpu_done) cpu_pend <= 1'b0;
      if (mcu_take) {mcu_pend, mcu_we_q, mcu_addr_q, mcu_din_q} <= {1'b1, mcu_we, mcu_addr, mcu_din};
      else if (mcu_done) mcu_pend <= 1'b0;
    end
  // access sequencer: pick a winner, drive one RAM cycle, then ack and return read data
  always_ff @(posedge CLK_32M or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      ram_cs <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      sel_mcu <= 1'b0;
      sel_pb <= 1'b0;
      cpu_ack <= 1'b0;
      mcu_ack <= 1'b0;
      cpu_rd <= 1'b0;
      mcu_rd <= 1'b0;
      cpu_dout_q <= '0;
      mcu_dout_q <= '0;
      starve <= '0;
      mcu_int <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      mcu_ack <= pb_take;
      case (state)
        IDLE: if (cpu_pend || mcu_any) begin
          state <= GRANT;
          ram_cs <= 1'b1;
          ram_we <= pick_mcu ? g_we : cpu_we_q;
          ram_addr <= pick_mcu ? g_addr : cpu_addr_q;
          ram_wdata <= pick_mcu ? g_din : cpu_din_q;
          sel_mcu <= pick_mcu;
          sel_pb <= pick_mcu && pb_v;
          starve <= pick_mcu ? '0 : starve + 1'b1;
        end
        GRANT: begin
          state <= DATA;
          ram_cs <= 1'b0;
          ram_we <= 1'b0;
          cpu_ack <= !sel_mcu;
          mcu_ack <= (sel_mcu && !sel_pb) || pb_take;
          cpu_rd <= !sel_mcu && !ram_we;
          mcu_rd <= sel_mcu && !sel_pb && !ram_we;
          if (!sel_mcu && ram_we && ram_addr == INT_ADDR) mcu_int <= 1'b1;
          else if (sel_mcu && !sel_pb && !ram_we && ram_addr == INT_ADDR) mcu_int <= 1'b0;
        end
        default: begin
          state <= IDLE;
          cpu_rd <= 1'b0;
          mcu_rd <= 1'b0;
          if (cpu_rd) cpu_dout_q <= ram_rdata;
          if (mcu_rd) mcu_dout_q <= ram_rdata;
        end
      endcase
      if (!mcu_any) starve <= '0;
    end
endmodule

// File: tb/tb_mcu_shared_ram_arbiter.sv
// tb_mcu_shared_ram_arbiter: directed bench for the shared RAM arbiter with a behavioural sync RAM.
module tb_mcu_shared_ram_arbiter;
  logic clk, reset_n;
  logic cpu_req, cpu_we, cpu_ack, mcu_req, mcu_we, mcu_ack, mcu_stall, ram_cs, ram_we, mcu_int;
  logic [11:0] cpu_addr, mcu_addr, ram_addr;
  logic [7:0] cpu_din, cpu_dout, mcu_din, mcu_dout, ram_wdata, ram_rdata;
  logic [7:0] mem [4096];
  logic [31:0] cm, mm;
  int checks = 0;
  int errors = 0;

  mcu_shared_ram_arbiter dut (
    .CLK_32M(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_addr(mcu_addr), .mcu_din(mcu_din),
    .mcu_dout(mcu_dout), .mcu_ack(mcu_ack), .mcu_stall(mcu_stall),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .mcu_int(mcu_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk)
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input logic [11:0] a, input logic [7:0] d);
    cpu_req = 1; cpu_we = 1; cpu_addr = a; cpu_din = d;
    tick; cpu_req = 0; tick; tick;
    chk("cpu_wr_ack", cpu_ack, 1);
    tick;
  endtask

  task automatic cpu_rd(input logic [11:0] a, input logic [7:0] exp);
    cpu_req = 1; cpu_we = 0; cpu_addr = a;
    tick; cpu_req = 0; tick; tick;
    chk("cpu_rd_ack", cpu_ack, 1);
    chk("cpu_rd_data", cpu_dout, exp);
    tick;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    ram_rdata = 8'h00;
    reset_n = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_din = 0;
    mcu_req = 0; mcu_we = 0; mcu_addr = 0; mcu_din = 0;
    tick; tick;
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_mcu_ack", mcu_ack, 0);
    chk("rst_stall", mcu_stall, 0);
    chk("rst_int", mcu_int, 0);
    chk("rst_ram_cs", ram_cs, 0);
    chk("rst_cpu_dout", cpu_dout, 0);
    chk("rst_mcu_dout", mcu_dout, 0);
    reset_n = 1;
    tick;
    // CPU write 0x123 <= 0x5A with cycle-by-cycle checks
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h123; cpu_din = 8'h5A;
    tick; cpu_req = 0;
    chk("wr_c1_ack", cpu_ack, 0);
    tick;
    chk("wr_c2_cs", ram_cs, 1);
    chk("wr_c2_we", ram_we, 1);
    chk("wr_c2_addr", ram_addr, 12'h123);
    chk("wr_c2_wdata", ram_wdata, 8'h5A);
    tick;
    chk("wr_c3_ack", cpu_ack, 1);
    tick;
    chk("wr_c4_ack", cpu_ack, 0);
    chk("wr_c4_cs", ram_cs, 0);
    cpu_rd(12'h123, 8'h5A);
    chk("rd_hold_dout", cpu_dout, 8'h5A);
    chk("rd_hold_ack", cpu_ack, 0);
    cpu_wr(12'h200, 8'h77);
    // simultaneous CPU and MCU reads
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h200;
    mcu_req = 1; mcu_we = 0; mcu_addr = 12'h123;
    tick; cpu_req = 0; mcu_req = 0;
    chk("sim_c1_stall", mcu_stall, 1);
    tick; tick;
    chk("sim_c3_cpu_ack", cpu_ack, 1);
    chk("sim_c3_cpu_dout", cpu_dout, 8'h77);
    chk("sim_c3_mcu_ack", mcu_ack, 0);
    chk("sim_c3_stall", mcu_stall, 1);
    tick; tick; tick;
    chk("sim_c6_mcu_ack", mcu_ack, 1);
    chk("sim_c6_mcu_dout", mcu_dout, 8'h5A);
    chk("sim_c6_stall", mcu_stall, 1);
    tick;
    chk("sim_c7_stall", mcu_stall, 0);
    chk("sim_c7_mcu_ack", mcu_ack, 0);
    chk("sim_c7_mcu_dout_hold", mcu_dout, 8'h5A);
    // starvation: CPU strobes every 3 cycles while MCU waits
    cm = 0; mm = 0;
    for (int c = 0; c < 20; c++) begin
      if (cpu_ack) cm[c] = 1'b1;
      if (mcu_ack) mm[c] = 1'b1;
      cpu_req = (c % 3 == 0) && c <= 12; cpu_we = 0; cpu_addr = 12'h200;
      mcu_req = c == 0; mcu_we = 0; mcu_addr = 12'h123;
      tick;
    end
    cpu_req = 0; mcu_req = 0;
    chk("starve_cpu_acks", cm, 32'h00041248);
    chk("starve_mcu_ack", mm, 32'h00008000);
    // mailbox interrupt
    cpu_wr(12'hFFF, 8'h01);
    chk("int_set", mcu_int, 1);
    mcu_req = 1; mcu_we = 0; mcu_addr = 12'hFFF;
    tick; mcu_req = 0; tick; tick;
    chk("int_rd_ack", mcu_ack, 1);
    chk("int_rd_data", mcu_dout, 8'h01);
    chk("int_clr", mcu_int, 0);
    tick;
    cpu_wr(12'hFFF, 8'h01);
    mcu_req = 1; mcu_we = 0; mcu_addr = 12'hFFF;
    tick; mcu_req = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'hFFF; cpu_din = 8'h02;
    tick; cpu_req = 0;
    tick;
    chk("ord_mcu_ack", mcu_ack, 1);
    chk("ord_int_clr", mcu_int, 0);
    tick; tick; tick;
    chk("ord_cpu_ack", cpu_ack, 1);
    chk("ord_int_set", mcu_int, 1);
    tick;
    // reset in the GRANT cycle of a CPU write
    cpu_wr(12'h010, 8'h33);
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h010; cpu_din = 8'hAA;
    tick; cpu_req = 0; tick;
    chk("rst_grant_cs", ram_cs, 1);
    #2 reset_n = 0;
    #1;
    chk("rst_async_cs", ram_cs, 0);
    tick;
    chk("rst_drop_ack", cpu_ack, 0);
    tick;
    reset_n = 1;
    tick; tick; tick;
    chk("rst_after_ack", cpu_ack, 0);
    chk("rst_after_int", mcu_int, 0);
    cpu_rd(12'h010, 8'h33);
`ifdef MCU_WRITE_POSTING_EN
    mcu_req = 1; mcu_we = 1; mcu_addr = 12'h321; mcu_din = 8'hC3;
    tick;
    chk("post_wr_ack", mcu_ack, 1);
    chk("post_wr_stall", mcu_stall, 0);
    mcu_we = 0;
    tick; mcu_req = 0;
    chk("post_rd_stall", mcu_stall, 1);
    chk("post_rd_c2_ack", mcu_ack, 0);
    tick; tick; tick; tick;
    chk("post_rd_ack", mcu_ack, 1);
    chk("post_rd_data", mcu_dout, 8'hC3);
    tick;
    chk("post_rd_stall_end", mcu_stall, 0);
`else
    mcu_req = 1; mcu_we = 1; mcu_addr = 12'h321; mcu_din = 8'hC3;
    tick; mcu_req = 0;
    chk("mwr_c1_stall", mcu_stall, 1);
    chk("mwr_c1_ack", mcu_ack, 0);
    tick; tick;
    chk("mwr_c3_ack", mcu_ack, 1);
    tick;
    chk("mwr_c4_stall", mcu_stall, 0);
`endif
    cpu_rd(12'h321, 8'hC3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
